// File: rtl/rat_ctrl_pkg.sv
// Shared types and encodings for the RAT MCU control sequencer.
// Optional interrupt support is selected with the RAT_INT_EN macro.
package rat_ctrl_pkg;

  localparam int unsigned ALU_SEL_WIDTH = 4;
  localparam int unsigned OPCODE_W      = 7;
  localparam int unsigned OPCODE_HI_W   = 5;

  typedef logic [ALU_SEL_WIDTH-1:0] alu_sel_t;
  typedef logic [OPCODE_W-1:0]      opcode_t;
  typedef logic [OPCODE_HI_W-1:0]   opcode_hi_t;

  // Sequencer states; ST_INTR only exists when interrupts are built in
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
`ifdef RAT_INT_EN
    ,
    ST_INTR  = 2'd3
`endif
  } state_t;

  // Register/register, branch and stack opcodes {OPCODE_HI_5, OPCODE_LO_2}
  localparam opcode_t OP_AND   = 7'b0000000;
  localparam opcode_t OP_OR    = 7'b0000001;
  localparam opcode_t OP_EXOR  = 7'b0000010;
  localparam opcode_t OP_TEST  = 7'b0000011;
  localparam opcode_t OP_ADD   = 7'b0000100;
  localparam opcode_t OP_ADDC  = 7'b0000101;
  localparam opcode_t OP_SUB   = 7'b0000110;
  localparam opcode_t OP_SUBC  = 7'b0000111;
  localparam opcode_t OP_CMP   = 7'b0001000;
  localparam opcode_t OP_MOV   = 7'b0001001;
  localparam opcode_t OP_LD    = 7'b0001010;
  localparam opcode_t OP_ST    = 7'b0001011;
  localparam opcode_t OP_BRN   = 7'b0010000;
  localparam opcode_t OP_CALL  = 7'b0010001;
  localparam opcode_t OP_BREQ  = 7'b0010010;
  localparam opcode_t OP_BRNE  = 7'b0010011;
  localparam opcode_t OP_BRCS  = 7'b0010100;
  localparam opcode_t OP_BRCC  = 7'b0010101;
  localparam opcode_t OP_LSL   = 7'b0100000;
  localparam opcode_t OP_LSR   = 7'b0100001;
  localparam opcode_t OP_ROL   = 7'b0100010;
  localparam opcode_t OP_ROR   = 7'b0100011;
  localparam opcode_t OP_ASR   = 7'b0100100;
  localparam opcode_t OP_PUSH  = 7'b0100101;
  localparam opcode_t OP_POP   = 7'b0100110;
  localparam opcode_t OP_RET   = 7'b0110010;
  localparam opcode_t OP_SEI   = 7'b0110100;
  localparam opcode_t OP_CLI   = 7'b0110101;
  localparam opcode_t OP_RETIE = 7'b0110111;

  // Immediate forms are identified by OPCODE_HI_5 alone
  localparam opcode_hi_t OPH_ANDI  = 5'b10000;
  localparam opcode_hi_t OPH_ORI   = 5'b10001;
  localparam opcode_hi_t OPH_EXORI = 5'b10010;
  localparam opcode_hi_t OPH_TESTI = 5'b10011;
  localparam opcode_hi_t OPH_ADDI  = 5'b10100;
  localparam opcode_hi_t OPH_ADDCI = 5'b10101;
  localparam opcode_hi_t OPH_SUBI  = 5'b10110;
  localparam opcode_hi_t OPH_SUBCI = 5'b10111;
  localparam opcode_hi_t OPH_CMPI  = 5'b11000;
  localparam opcode_hi_t OPH_IN    = 5'b11001;
  localparam opcode_hi_t OPH_OUT   = 5'b11010;
  localparam opcode_hi_t OPH_MOVI  = 5'b11011;
  localparam opcode_hi_t OPH_LDI   = 5'b11100;
  localparam opcode_hi_t OPH_STI   = 5'b11101;

  // PC mux selects
  localparam logic [1:0] PC_SEL_IMM   = 2'd0;
  localparam logic [1:0] PC_SEL_STACK = 2'd1;
  localparam logic [1:0] PC_SEL_VEC   = 2'd2;

  // Register-file write-data selects
  localparam logic [1:0] RF_SEL_ALU = 2'd0;
  localparam logic [1:0] RF_SEL_SCR = 2'd1;
  localparam logic [1:0] RF_SEL_B   = 2'd2;
  localparam logic [1:0] RF_SEL_IN  = 2'd3;

  // Scratch RAM address selects
  localparam logic [1:0] SCR_SEL_DY   = 2'd0;
  localparam logic [1:0] SCR_SEL_IMM  = 2'd1;
  localparam logic [1:0] SCR_SEL_SP   = 2'd2;
  localparam logic [1:0] SCR_SEL_SPM1 = 2'd3;

  // ALU function codes
  localparam alu_sel_t ALU_ADD  = ALU_SEL_WIDTH'(0);
  localparam alu_sel_t ALU_ADDC = ALU_SEL_WIDTH'(1);
  localparam alu_sel_t ALU_SUB  = ALU_SEL_WIDTH'(2);
  localparam alu_sel_t ALU_SUBC = ALU_SEL_WIDTH'(3);
  localparam alu_sel_t ALU_CMP  = ALU_SEL_WIDTH'(4);
  localparam alu_sel_t ALU_AND  = ALU_SEL_WIDTH'(5);
  localparam alu_sel_t ALU_OR   = ALU_SEL_WIDTH'(6);
  localparam alu_sel_t ALU_EXOR = ALU_SEL_WIDTH'(7);
  localparam alu_sel_t ALU_TEST = ALU_SEL_WIDTH'(8);
  localparam alu_sel_t ALU_LSL  = ALU_SEL_WIDTH'(9);
  localparam alu_sel_t ALU_LSR  = ALU_SEL_WIDTH'(10);
  localparam alu_sel_t ALU_ROL  = ALU_SEL_WIDTH'(11);
  localparam alu_sel_t ALU_ROR  = ALU_SEL_WIDTH'(12);
  localparam alu_sel_t ALU_ASR  = ALU_SEL_WIDTH'(13);

  // Full set of datapath controls produced each cycle
  typedef struct packed {
    logic       pc_ld;
    logic       pc_inc;
    logic [1:0] pc_mux_sel;
    logic       rf_wr;
    logic [1:0] rf_wr_sel;
    logic       alu_opy_sel;
    alu_sel_t   alu_sel;
    logic       scr_we;
    logic [1:0] scr_addr_sel;
    logic       sp_incr;
    logic       sp_decr;
    logic       flg_c_ld;
    logic       flg_z_ld;
    logic       flg_ld_sel;
    logic       flg_shad_ld;
    logic       i_set;
    logic       i_clr;
    logic       io_strb;
    logic       rst_out;
  } ctrl_t;

  // ALU instruction: result to reg file unless compare-only, C and Z always loaded
  function automatic ctrl_t alu_ctrl(input alu_sel_t sel, input logic imm, input logic wr);
    ctrl_t c;
    c             = '0;
    c.rf_wr       = wr;
    c.rf_wr_sel   = RF_SEL_ALU;
    c.alu_opy_sel = imm;
    c.alu_sel     = sel;
    c.flg_c_ld    = 1'b1;
    c.flg_z_ld    = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/rat_ctrl_sequencer_if.sv
// Instruction/flag inputs and datapath control outputs of the RAT sequencer.
interface rat_ctrl_sequencer_if #(
  parameter int unsigned ALU_SEL_W = 4
);
  logic [4:0]           OPCODE_HI_5;
  logic [1:0]           OPCODE_LO_2;
  logic                 C_FLAG;
  logic                 Z_FLAG;
  logic                 INT;
  logic                 I_FLAG;
  logic                 PC_LD;
  logic                 PC_INC;
  logic [1:0]           PC_MUX_SEL;
  logic                 RF_WR;
  logic [1:0]           RF_WR_SEL;
  logic                 ALU_OPY_SEL;
  logic [ALU_SEL_W-1:0] ALU_SEL;
  logic                 SCR_WE;
  logic [1:0]           SCR_ADDR_SEL;
  logic                 SP_INCR;
  logic                 SP_DECR;
  logic                 FLG_C_LD;
  logic                 FLG_Z_LD;
  logic                 FLG_LD_SEL;
  logic                 FLG_SHAD_LD;
  logic                 I_SET;
  logic                 I_CLR;
  logic                 IO_STRB;
  logic                 RST_OUT;

  // Sequencer side
  modport master (
    input  OPCODE_HI_5, OPCODE_LO_2, C_FLAG, Z_FLAG, INT, I_FLAG,
    output PC_LD, PC_INC, PC_MUX_SEL, RF_WR, RF_WR_SEL, ALU_OPY_SEL, ALU_SEL,
           SCR_WE, SCR_ADDR_SEL, SP_INCR, SP_DECR, FLG_C_LD, FLG_Z_LD,
           FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, IO_STRB, RST_OUT
  );

  // Datapath side
  modport slave (
    output OPCODE_HI_5, OPCODE_LO_2, C_FLAG, Z_FLAG, INT, I_FLAG,
    input  PC_LD, PC_INC, PC_MUX_SEL, RF_WR, RF_WR_SEL, ALU_OPY_SEL, ALU_SEL,
           SCR_WE, SCR_ADDR_SEL, SP_INCR, SP_DECR, FLG_C_LD, FLG_Z_LD,
           FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, IO_STRB, RST_OUT
  );
endinterface

// File: rtl/rat_ctrl_decoder.sv
// Pure combinational EXEC-cycle instruction decode for the RAT MCU.
// With RAT_INT_EN undefined RETIE behaves as RET and SEI/CLI are undefined.
module rat_ctrl_decoder
  import rat_ctrl_pkg::*;
(
  input  opcode_t opcode,
  input  logic    c_flag,
  input  logic    z_flag,
  output ctrl_t   ctrl
);

  // Opcode to control-word decode; anything unlisted leaves every strobe low
  always_comb begin
    ctrl = '0;
    if (opcode[6]) begin
      case (opcode[6:2])
        OPH_ANDI:  ctrl = alu_ctrl(ALU_AND,  1'b1, 1'b1);
        OPH_ORI:   ctrl = alu_ctrl(ALU_OR,   1'b1, 1'b1);
        OPH_EXORI: ctrl = alu_ctrl(ALU_EXOR, 1'b1, 1'b1);
        OPH_TESTI: ctrl = alu_ctrl(ALU_TEST, 1'b1, 1'b0);
        OPH_ADDI:  ctrl = alu_ctrl(ALU_ADD,  1'b1, 1'b1);
        OPH_ADDCI: ctrl = alu_ctrl(ALU_ADDC, 1'b1, 1'b1);
        OPH_SUBI:  ctrl = alu_ctrl(ALU_SUB,  1'b1, 1'b1);
        OPH_SUBCI: ctrl = alu_ctrl(ALU_SUBC, 1'b1, 1'b1);
        OPH_CMPI:  ctrl = alu_ctrl(ALU_CMP,  1'b1, 1'b0);
        OPH_IN: begin
          ctrl.rf_wr     = 1'b1;
          ctrl.rf_wr_sel = RF_SEL_IN;
        end
        OPH_OUT:   ctrl.io_strb = 1'b1;
        OPH_MOVI: begin
          ctrl.rf_wr       = 1'b1;
          ctrl.rf_wr_sel   = RF_SEL_B;
          ctrl.alu_opy_sel = 1'b1;
        end
        OPH_LDI: begin
          ctrl.rf_wr        = 1'b1;
          ctrl.rf_wr_sel    = RF_SEL_SCR;
          ctrl.scr_addr_sel = SCR_SEL_IMM;
        end
        OPH_STI: begin
          ctrl.scr_we       = 1'b1;
          ctrl.scr_addr_sel = SCR_SEL_IMM;
        end
        default: ;
      endcase
    end else begin
      case (opcode)
        OP_AND:  ctrl = alu_ctrl(ALU_AND,  1'b0, 1'b1);
        OP_OR:   ctrl = alu_ctrl(ALU_OR,   1'b0, 1'b1);
        OP_EXOR: ctrl = alu_ctrl(ALU_EXOR, 1'b0, 1'b1);
        OP_TEST: ctrl = alu_ctrl(ALU_TEST, 1'b0, 1'b0);
        OP_ADD:  ctrl = alu_ctrl(ALU_ADD,  1'b0, 1'b1);
        OP_ADDC: ctrl = alu_ctrl(ALU_ADDC, 1'b0, 1'b1);
        OP_SUB:  ctrl = alu_ctrl(ALU_SUB,  1'b0, 1'b1);
        OP_SUBC: ctrl = alu_ctrl(ALU_SUBC, 1'b0, 1'b1);
        OP_CMP:  ctrl = alu_ctrl(ALU_CMP,  1'b0, 1'b0);
        OP_LSL:  ctrl = alu_ctrl(ALU_LSL,  1'b0, 1'b1);
        OP_LSR:  ctrl = alu_ctrl(ALU_LSR,  1'b0, 1'b1);
        OP_ROL:  ctrl = alu_ctrl(ALU_ROL,  1'b0, 1'b1);
        OP_ROR:  ctrl = alu_ctrl(ALU_ROR,  1'b0, 1'b1);
        OP_ASR:  ctrl = alu_ctrl(ALU_ASR,  1'b0, 1'b1);
        OP_MOV: begin
          ctrl.rf_wr     = 1'b1;
          ctrl.rf_wr_sel = RF_SEL_B;
        end
        OP_LD: begin
          ctrl.rf_wr        = 1'b1;
          ctrl.rf_wr_sel    = RF_SEL_SCR;
          ctrl.scr_addr_sel = SCR_SEL_DY;
        end
        OP_ST: begin
          ctrl.scr_we       = 1'b1;
          ctrl.scr_addr_sel = SCR_SEL_DY;
        end
        OP_BRN:  ctrl.pc_ld = 1'b1;
        OP_BREQ: ctrl.pc_ld = z_flag;
        OP_BRNE: ctrl.pc_ld = ~z_flag;
        OP_BRCS: ctrl.pc_ld = c_flag;
        OP_BRCC: ctrl.pc_ld = ~c_flag;
        OP_CALL: begin
          ctrl.pc_ld        = 1'b1;
          ctrl.pc_mux_sel   = PC_SEL_IMM;
          ctrl.scr_we       = 1'b1;
          ctrl.scr_addr_sel = SCR_SEL_SPM1;
          ctrl.sp_decr      = 1'b1;
        end
        OP_RET: begin
          ctrl.pc_ld        = 1'b1;
          ctrl.pc_mux_sel   = PC_SEL_STACK;
          ctrl.scr_addr_sel = SCR_SEL_SP;
          ctrl.sp_incr      = 1'b1;
        end
        OP_RETIE: begin
          ctrl.pc_ld        = 1'b1;
          ctrl.pc_mux_sel   = PC_SEL_STACK;
          ctrl.scr_addr_sel = SCR_SEL_SP;
          ctrl.sp_incr      = 1'b1;
`ifdef RAT_INT_EN
          ctrl.flg_ld_sel   = 1'b1;
          ctrl.flg_c_ld     = 1'b1;
          ctrl.flg_z_ld     = 1'b1;
          ctrl.i_set        = 1'b1;
`endif
        end
        OP_PUSH: begin
          ctrl.scr_we       = 1'b1;
          ctrl.scr_addr_sel = SCR_SEL_SPM1;
          ctrl.sp_decr      = 1'b1;
        end
        OP_POP: begin
          ctrl.rf_wr        = 1'b1;
          ctrl.rf_wr_sel    = RF_SEL_SCR;
          ctrl.scr_addr_sel = SCR_SEL_SP;
          ctrl.sp_incr      = 1'b1;
        end
`ifdef RAT_INT_EN
        OP_SEI:  ctrl.i_set = 1'b1;
        OP_CLI:  ctrl.i_clr = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rat_ctrl_sequencer.sv
// RAT MCU multi-cycle control FSM: INIT -> FETCH -> EXEC (-> INTR).
// Interrupt state and strobes are built only when RAT_INT_EN is defined.
// Outputs are combinational from state, opcode and flags; only the state is registered.
module rat_ctrl_sequencer
  import rat_ctrl_pkg::*;
#(
  parameter int unsigned ALU_SEL_W = ALU_SEL_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RST,
  rat_ctrl_sequencer_if.master    bus
);

  state_t state;
  state_t state_next;
  ctrl_t  dec_ctrl;
  ctrl_t  ctrl;

  rat_ctrl_decoder u_decoder (
    .opcode (opcode_t'({bus.OPCODE_HI_5, bus.OPCODE_LO_2})),
    .c_flag (bus.C_FLAG),
    .z_flag (bus.Z_FLAG),
    .ctrl   (dec_ctrl)
  );

`ifndef RAT_INT_EN
  logic unused_irq;
  assign unused_irq = bus.INT ^ bus.I_FLAG;
`endif

  // State register with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_INIT;
    else     state <= state_next;
  end

  // Next state and control word; reset overrides whatever state we are in
  always_comb begin
    ctrl       = '0;
    state_next = state;
    if (RST) begin
      ctrl.rst_out = 1'b1;
      state_next   = ST_INIT;
    end else begin
      case (state)
        ST_INIT: begin
          ctrl.rst_out = 1'b1;
          state_next   = ST_FETCH;
        end
        ST_FETCH: begin
          ctrl.pc_inc = 1'b1;
          state_next  = ST_EXEC;
        end
        ST_EXEC: begin
          ctrl       = dec_ctrl;
          state_next = ST_FETCH;
`ifdef RAT_INT_EN
          if (bus.INT && bus.I_FLAG) state_next = ST_INTR;
`endif
        end
`ifdef RAT_INT_EN
        ST_INTR: begin
          ctrl.pc_ld        = 1'b1;
          ctrl.pc_mux_sel   = PC_SEL_VEC;
          ctrl.scr_we       = 1'b1;
          ctrl.scr_addr_sel = SCR_SEL_SPM1;
          ctrl.sp_decr      = 1'b1;
          ctrl.flg_shad_ld  = 1'b1;
          ctrl.i_clr        = 1'b1;
          state_next        = ST_FETCH;
        end
`endif
        default: state_next = ST_INIT;
      endcase
    end
  end

  assign bus.PC_LD        = ctrl.pc_ld;
  assign bus.PC_INC       = ctrl.pc_inc;
  assign bus.PC_MUX_SEL   = ctrl.pc_mux_sel;
  assign bus.RF_WR        = ctrl.rf_wr;
  assign bus.RF_WR_SEL    = ctrl.rf_wr_sel;
  assign bus.ALU_OPY_SEL  = ctrl.alu_opy_sel;
  assign bus.ALU_SEL      = ALU_SEL_W'(ctrl.alu_sel);
  assign bus.SCR_WE       = ctrl.scr_we;
  assign bus.SCR_ADDR_SEL = ctrl.scr_addr_sel;
  assign bus.SP_INCR      = ctrl.sp_incr;
  assign bus.SP_DECR      = ctrl.sp_decr;
  assign bus.FLG_C_LD     = ctrl.flg_c_ld;
  assign bus.FLG_Z_LD     = ctrl.flg_z_ld;
  assign bus.FLG_LD_SEL   = ctrl.flg_ld_sel;
  assign bus.FLG_SHAD_LD  = ctrl.flg_shad_ld;
  assign bus.I_SET        = ctrl.i_set;
  assign bus.I_CLR        = ctrl.i_clr;
  assign bus.IO_STRB      = ctrl.io_strb;
  assign bus.RST_OUT      = ctrl.rst_out;

endmodule

// File: tb/tb_rat_ctrl_sequencer.sv
// Self-checking bench for rat_ctrl_sequencer against a mnemonic-level reference model.
// Honours RAT_INT_EN the same way as the design.
module tb_rat_ctrl_sequencer;

  localparam int unsigned ALU_W = 4;
`ifdef RAT_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  localparam int P_UNK = -1, P_INIT = 0, P_FETCH = 1, P_EXEC = 2, P_INTR = 3;

  typedef enum {
    M_UNDEF, M_AND, M_OR, M_EXOR, M_TEST, M_ADD, M_ADDC, M_SUB, M_SUBC, M_CMP,
    M_LSL, M_LSR, M_ROL, M_ROR, M_ASR, M_MOV, M_LD, M_ST, M_IN, M_OUT,
    M_BRN, M_BREQ, M_BRNE, M_BRCS, M_BRCC, M_CALL, M_RET, M_RETIE,
    M_PUSH, M_POP, M_SEI, M_CLI
  } mn_t;

  typedef struct packed {
    logic             pc_ld;
    logic             pc_inc;
    logic [1:0]       pc_sel;
    logic             rf_wr;
    logic [1:0]       rf_sel;
    logic             opy;
    logic [ALU_W-1:0] alu;
    logic             scr_we;
    logic [1:0]       scr_sel;
    logic             sp_inc;
    logic             sp_dec;
    logic             c_ld;
    logic             z_ld;
    logic             ld_sel;
    logic             shad;
    logic             i_set;
    logic             i_clr;
    logic             io;
    logic             rst_out;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   phase = P_UNK;
  bit   cur_irq, cur_ien, cur_rst;

  rat_ctrl_sequencer_if #(.ALU_SEL_W(ALU_W)) bus ();

  rat_ctrl_sequencer #(.ALU_SEL_W(ALU_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic mn_t mnemonic(input logic [6:0] op, output bit imm);
    mn_t m;
    m   = M_UNDEF;
    imm = op[6];
    if (op[6]) begin
      case (op[6:2])
        5'b10000: m = M_AND;   5'b10001: m = M_OR;   5'b10010: m = M_EXOR;
        5'b10011: m = M_TEST;  5'b10100: m = M_ADD;  5'b10101: m = M_ADDC;
        5'b10110: m = M_SUB;   5'b10111: m = M_SUBC; 5'b11000: m = M_CMP;
        5'b11001: m = M_IN;    5'b11010: m = M_OUT;  5'b11011: m = M_MOV;
        5'b11100: m = M_LD;    5'b11101: m = M_ST;
        default:  m = M_UNDEF;
      endcase
    end else begin
      case (op)
        7'd0:  m = M_AND;  7'd1:  m = M_OR;   7'd2:  m = M_EXOR; 7'd3:  m = M_TEST;
        7'd4:  m = M_ADD;  7'd5:  m = M_ADDC; 7'd6:  m = M_SUB;  7'd7:  m = M_SUBC;
        7'd8:  m = M_CMP;  7'd9:  m = M_MOV;  7'd10: m = M_LD;   7'd11: m = M_ST;
        7'd16: m = M_BRN;  7'd17: m = M_CALL; 7'd18: m = M_BREQ; 7'd19: m = M_BRNE;
        7'd20: m = M_BRCS; 7'd21: m = M_BRCC;
        7'd32: m = M_LSL;  7'd33: m = M_LSR;  7'd34: m = M_ROL;  7'd35: m = M_ROR;
        7'd36: m = M_ASR;  7'd37: m = M_PUSH; 7'd38: m = M_POP;
        7'd50: m = M_RET;  7'd52: m = M_SEI;  7'd53: m = M_CLI;  7'd55: m = M_RETIE;
        default: m = M_UNDEF;
      endcase
    end
    return m;
  endfunction

  function automatic int alu_code(input mn_t m);
    case (m)
      M_ADD: return 0;  M_ADDC: return 1;  M_SUB: return 2;  M_SUBC: return 3;
      M_CMP: return 4;  M_AND:  return 5;  M_OR:  return 6;  M_EXOR: return 7;
      M_TEST: return 8; M_LSL:  return 9;  M_LSR: return 10; M_ROL:  return 11;
      M_ROR: return 12; M_ASR:  return 13;
      default: return -1;
    endcase
  endfunction

  function automatic exp_t exec_model(input logic [6:0] op, input logic c, input logic z);
    exp_t e;
    bit   imm;
    mn_t  m;
    e = '0;
    m = mnemonic(op, imm);
    if (alu_code(m) >= 0) begin
      e.rf_wr = (m != M_TEST) && (m != M_CMP);
      e.opy   = imm;
      e.alu   = ALU_W'(alu_code(m));
      e.c_ld  = 1'b1;
      e.z_ld  = 1'b1;
    end else begin
      case (m)
        M_MOV:  begin e.rf_wr = 1'b1; e.rf_sel = 2'd2; e.opy = imm; end
        M_LD:   begin e.rf_wr = 1'b1; e.rf_sel = 2'd1; e.scr_sel = imm ? 2'd1 : 2'd0; end
        M_ST:   begin e.scr_we = 1'b1; e.scr_sel = imm ? 2'd1 : 2'd0; end
        M_IN:   begin e.rf_wr = 1'b1; e.rf_sel = 2'd3; end
        M_OUT:  e.io = 1'b1;
        M_BRN:  e.pc_ld = 1'b1;
        M_BREQ: e.pc_ld = z;
        M_BRNE: e.pc_ld = !z;
        M_BRCS: e.pc_ld = c;
        M_BRCC: e.pc_ld = !c;
        M_CALL: begin e.pc_ld = 1'b1; e.scr_we = 1'b1; e.scr_sel = 2'd3; e.sp_dec = 1'b1; end
        M_RET, M_RETIE: begin
          e.pc_ld = 1'b1; e.pc_sel = 2'd1; e.scr_sel = 2'd2; e.sp_inc = 1'b1;
          if (m == M_RETIE && INT_EN) begin
            e.ld_sel = 1'b1; e.c_ld = 1'b1; e.z_ld = 1'b1; e.i_set = 1'b1;
          end
        end
        M_PUSH: begin e.scr_we = 1'b1; e.scr_sel = 2'd3; e.sp_dec = 1'b1; end
        M_POP:  begin e.rf_wr = 1'b1; e.rf_sel = 2'd1; e.scr_sel = 2'd2; e.sp_inc = 1'b1; end
        M_SEI:  e.i_set = INT_EN;
        M_CLI:  e.i_clr = INT_EN;
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic exp_t model(input int ph, input logic [6:0] op, input logic c,
                                 input logic z, input logic r);
    exp_t e;
    e = '0;
    if (r) begin
      e.rst_out = 1'b1;
      return e;
    end
    case (ph)
      P_INIT:  e.rst_out = 1'b1;
      P_FETCH: e.pc_inc = 1'b1;
      P_EXEC:  e = exec_model(op, c, z);
      P_INTR: begin
        e.pc_ld = 1'b1; e.pc_sel = 2'd2; e.scr_we = 1'b1; e.scr_sel = 2'd3;
        e.sp_dec = 1'b1; e.shad = 1'b1; e.i_clr = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic int next_phase(input int ph, input bit irq, input bit ien, input bit r);
    if (r) return P_INIT;
    case (ph)
      P_INIT:  return P_FETCH;
      P_FETCH: return P_EXEC;
      P_EXEC:  return (INT_EN && irq && ien) ? P_INTR : P_FETCH;
      P_INTR:  return P_FETCH;
      default: return P_UNK;
    endcase
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.pc_ld   = bus.PC_LD;       a.pc_inc  = bus.PC_INC;     a.pc_sel = bus.PC_MUX_SEL;
    a.rf_wr   = bus.RF_WR;       a.rf_sel  = bus.RF_WR_SEL;  a.opy    = bus.ALU_OPY_SEL;
    a.alu     = bus.ALU_SEL;     a.scr_we  = bus.SCR_WE;     a.scr_sel = bus.SCR_ADDR_SEL;
    a.sp_inc  = bus.SP_INCR;     a.sp_dec  = bus.SP_DECR;    a.c_ld   = bus.FLG_C_LD;
    a.z_ld    = bus.FLG_Z_LD;    a.ld_sel  = bus.FLG_LD_SEL; a.shad   = bus.FLG_SHAD_LD;
    a.i_set   = bus.I_SET;       a.i_clr   = bus.I_CLR;      a.io     = bus.IO_STRB;
    a.rst_out = bus.RST_OUT;
    return a;
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic drive(input logic [6:0] op, input logic c, input logic z,
                       input logic irq, input logic ien, input logic r);
    bus.OPCODE_HI_5 = op[6:2];
    bus.OPCODE_LO_2 = op[1:0];
    bus.C_FLAG      = c;
    bus.Z_FLAG      = z;
    bus.INT         = irq;
    bus.I_FLAG      = ien;
    rst             = r;
    cur_irq = irq; cur_ien = ien; cur_rst = r;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    phase = next_phase(phase, cur_irq, cur_ien, cur_rst);
    @(negedge clk);
  endtask

  task automatic goto_exec();
    for (int i = 0; i < 4 && phase != P_EXEC; i++) begin
      drive(7'($urandom_range(0, 127)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      advance();
    end
    if (phase != P_EXEC) begin
      n_cmp++; n_err++;
      $display("FAIL goto_exec: model never reached EXEC (phase %0d)", phase);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    exp_t e, a;
    logic [6:0] op;
    drive(7'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e = model(P_UNK, 7'h11, 1'b0, 1'b0, 1'b1); a = actual(); n_cmp++;
    if (a !== e) begin n_err++; $display("FAIL reset_cycle: got %h expected %h", a, e); end
    advance();
    for (int k = 0; k < 3; k++) begin
      op = (k == 2) ? 7'b1010001 : 7'h11;
      drive(op, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      e = model(phase, op, 1'b0, 1'b0, 1'b0); a = actual(); n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL reset_seq[%0d] phase %0d: got %h expected %h", k, phase, a, e); end
      advance();
    end
  endtask

  task automatic test_branch();
    exp_t e, a;
    logic [6:0] brs [5] = '{7'd16, 7'd18, 7'd19, 7'd20, 7'd21};
    // BREQ not taken then taken
    for (int zf = 0; zf < 2; zf++) begin
      goto_exec();
      drive(7'd18, 1'b0, 1'(zf), 1'b0, 1'b0, 1'b0);
      e = model(phase, 7'd18, 1'b0, 1'(zf), 1'b0); a = actual(); n_cmp++;
      if (a !== e || bus.PC_LD !== 1'(zf)) begin
        n_err++; $display("FAIL breq_z%0d: got %h expected %h", zf, a, e);
      end
      advance();
    end
    foreach (brs[i]) begin
      for (int f = 0; f < 4; f++) begin
        goto_exec();
        drive(brs[i], 1'(f >> 1), 1'(f), 1'b0, 1'b0, 1'b0);
        e = model(phase, brs[i], 1'(f >> 1), 1'(f), 1'b0); a = actual(); n_cmp++;
        if (a !== e) begin n_err++; $display("FAIL branch op=%b cz=%0d: got %h expected %h", brs[i], f, a, e); end
        advance();
      end
    end
  endtask

  task automatic test_call_ret();
    exp_t e, a;
    goto_exec();
    drive(7'd17, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e = model(phase, 7'd17, 1'b0, 1'b0, 1'b0); a = actual(); n_cmp++;
    if (a !== e || bus.SCR_ADDR_SEL !== 2'd3 || bus.SP_DECR !== 1'b1) begin
      n_err++; $display("FAIL call: got %h expected %h", a, e);
    end
    advance();
    goto_exec();
    drive(7'd50, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    e = model(phase, 7'd50, 1'b1, 1'b1, 1'b0); a = actual(); n_cmp++;
    if (a !== e || bus.PC_MUX_SEL !== 2'd1 || bus.SP_INCR !== 1'b1) begin
      n_err++; $display("FAIL ret: got %h expected %h", a, e);
    end
    advance();
  endtask

  task automatic test_alu_imm();
    exp_t e, a;
    logic [6:0] op;
    for (int i = 0; i < 16; i++) begin
      op = (i < 6) ? {5'b10100, 2'(i)} : {5'(16 + $urandom_range(0, 8)), 2'($urandom_range(0, 3))};
      goto_exec();
      drive(op, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
      e = model(phase, op, bus.C_FLAG, bus.Z_FLAG, 1'b0); a = actual(); n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL alu_imm op=%b: got %h expected %h", op, a, e); end
      advance();
    end
  endtask

  task automatic test_intr();
    exp_t e, a;
    goto_exec();
    drive(7'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    e = model(phase, 7'd9, 1'b0, 1'b0, 1'b0); a = actual(); n_cmp++;
    if (a !== e) begin n_err++; $display("FAIL intr_exec: got %h expected %h", a, e); end
    advance();
    // I_FLAG now cleared externally; INT still high
    drive(7'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    e = model(phase, 7'd9, 1'b0, 1'b0, 1'b0); a = actual(); n_cmp++;
    if (a !== e) begin n_err++; $display("FAIL intr_entry phase %0d: got %h expected %h", phase, a, e); end
    advance();
    goto_exec();
    drive(7'd55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e = model(phase, 7'd55, 1'b0, 1'b1, 1'b0); a = actual(); n_cmp++;
    if (a !== e) begin n_err++; $display("FAIL retie: got %h expected %h", a, e); end
    advance();
  endtask

  task automatic test_rst_mid_exec();
    exp_t e, a;
    goto_exec();
    drive(7'd17, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e = model(phase, 7'd17, 1'b0, 1'b0, 1'b1); a = actual(); n_cmp++;
    if (a !== e || bus.SCR_WE !== 1'b0 || bus.SP_DECR !== 1'b0 || bus.RST_OUT !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_call: got %h expected %h", a, e);
    end
    advance();
    drive(7'd17, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e = model(phase, 7'd17, 1'b0, 1'b0, 1'b0); a = actual(); n_cmp++;
    if (a !== e) begin n_err++; $display("FAIL rst_then_init: got %h expected %h", a, e); end
    advance();
  endtask

  task automatic test_random();
    exp_t e, a;
    logic [6:0] op;
    logic c, z, irq, ien, r;
    for (int i = 0; i < 400; i++) begin
      op  = 7'($urandom_range(0, 127));
      c   = 1'($urandom); z = 1'($urandom);
      irq = ($urandom_range(0, 3) == 0);
      ien = 1'($urandom);
      r   = ($urandom_range(0, 39) == 0);
      drive(op, c, z, irq, ien, r);
      e = model(phase, op, c, z, r); a = actual(); n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL random[%0d] phase %0d op=%b: got %h expected %h", i, phase, op, a, e); end
      n_cmp++;
      if ((a.pc_ld && a.pc_inc) || (a.sp_inc && a.sp_dec)) begin
        n_err++; $display("FAIL exclusive[%0d]: got %h expected no PC_LD/PC_INC or SP_INCR/SP_DECR pair", i, a);
      end
      advance();
    end
  endtask

  initial begin
    drive(7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    test_reset();
    test_branch();
    test_call_ret();
    test_alu_imm();
    test_intr();
    test_rst_mid_exec();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
